// File: rtl/i2c_target_responder.sv
// I2C target: synchronised SCL/SDA, START/Sr/STOP decode, address match, RX/TX byte ports.
// Optional I2C_TARGET_CLK_STRETCH_EN: stretch SCL on TX underrun instead of sending 8'hFF.
module i2c_target_responder #(
    parameter logic [6:0] SLV_ADDR    = 7'h22,
    parameter int         NUM_SYNC    = 2,
    parameter int         HOLD_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_drive_low_o,
    output logic       sda_drive_low_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       start_o,
    output logic       stop_o,
    output logic       nack_o,
    output logic       underrun_o,
    output logic       busy_o
);

    localparam int NS = (NUM_SYNC < 2) ? 2 : NUM_SYNC;
    localparam int HW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } state_t;

    state_t        state;
    logic [NS-1:0] scl_sync;
    logic [NS-1:0] sda_sync;
    logic          scl_p;
    logic          sda_p;
    logic          scl_s;
    logic          sda_s;
    logic          scl_rise;
    logic          scl_fall;
    logic          start_det;
    logic          stop_det;
    logic          hold_act;
    logic [HW-1:0] hold_cnt;
    logic          fall_evt;
    logic [3:0]    cnt;
    logic [3:0]    cnt_inc;
    logic [7:0]    shreg;
    logic [7:0]    sh_in;
    logic          rw;
    logic          ack_wr;
    logic          latch_pt;

    // Bus idles high, so the synchronisers come out of reset at 1.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[NS-2:0], scl_i};
            sda_sync <= {sda_sync[NS-2:0], sda_i};
            scl_p    <= scl_sync[NS-1];
            sda_p    <= sda_sync[NS-1];
        end
    end

    assign scl_s     = scl_sync[NS-1];
    assign sda_s     = sda_sync[NS-1];
    assign scl_rise  = scl_s & ~scl_p;
    assign scl_fall  = ~scl_s & scl_p;
    assign start_det = scl_s & scl_p & sda_p & ~sda_s;
    assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

    // Delayed falling-edge event: all SDA drive changes happen here.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_act <= 1'b0;
            hold_cnt <= '0;
        end else if (start_det || stop_det) begin
            hold_act <= 1'b0;
        end else if (scl_fall) begin
            hold_act <= 1'b1;
            hold_cnt <= HW'(HOLD_CYCLES);
        end else if (hold_act) begin
            if (hold_cnt == '0) hold_act <= 1'b0;
            else                hold_cnt <= hold_cnt - 1'b1;
        end
    end

    assign fall_evt = hold_act && (hold_cnt == '0);
    assign cnt_inc  = (cnt == 4'd9) ? cnt : cnt + 4'd1;
    assign sh_in    = {shreg[6:0], sda_s};
    assign latch_pt = fall_evt && (cnt == 4'd9) &&
                      ((state == ADDR_ACK && rw) || state == RD_ACK);

`ifdef I2C_TARGET_CLK_STRETCH_EN
    logic          scl_drv;
    logic          stretch;
    logic          rel_act;
    logic [HW-1:0] rel_cnt;

    assign scl_drive_low_o = scl_drv;
    assign tx_ready_o      = tx_valid_i & ~start_det & ~stop_det &
                             (latch_pt | stretch);
`else
    assign scl_drive_low_o = 1'b0;
    assign tx_ready_o      = tx_valid_i & ~start_det & ~stop_det & latch_pt;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state           <= IDLE;
            cnt             <= 4'd0;
            shreg           <= 8'h00;
            rw              <= 1'b0;
            ack_wr          <= 1'b0;
            sda_drive_low_o <= 1'b0;
            rx_data_o       <= 8'h00;
            rx_valid_o      <= 1'b0;
            start_o         <= 1'b0;
            stop_o          <= 1'b0;
            nack_o          <= 1'b0;
            underrun_o      <= 1'b0;
            busy_o          <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
            scl_drv         <= 1'b0;
            stretch         <= 1'b0;
            rel_act         <= 1'b0;
            rel_cnt         <= '0;
`endif
        end else begin
            rx_valid_o <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            nack_o     <= 1'b0;
            underrun_o <= 1'b0;
            if (start_det) begin
                state           <= ADDR;
                cnt             <= 4'd0;
                busy_o          <= 1'b1;
                start_o         <= 1'b1;
                sda_drive_low_o <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
                scl_drv         <= 1'b0;
                stretch         <= 1'b0;
                rel_act         <= 1'b0;
`endif
            end else if (stop_det) begin
                state           <= IDLE;
                cnt             <= 4'd0;
                busy_o          <= 1'b0;
                stop_o          <= 1'b1;
                sda_drive_low_o <= 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
                scl_drv         <= 1'b0;
                stretch         <= 1'b0;
                rel_act         <= 1'b0;
`endif
            end else begin
                if (scl_rise) begin
                    cnt <= cnt_inc;
                    case (state)
                        ADDR: begin
                            shreg <= sh_in;
                            if (cnt == 4'd7) begin
                                rw <= sda_s;
                                if (sh_in[7:1] == SLV_ADDR) state <= ADDR_ACK;
                                else                        state <= IGNORE;
                            end
                        end
                        WR_BYTE: begin
                            shreg <= sh_in;
                            if (cnt == 4'd7) begin
                                ack_wr <= rx_ready_i;
                                state  <= WR_ACK;
                                if (rx_ready_i) begin
                                    rx_data_o  <= sh_in;
                                    rx_valid_o <= 1'b1;
                                end
                            end
                        end
                        RD_ACK: begin
                            if (cnt == 4'd8 && sda_s) begin
                                nack_o <= 1'b1;
                                state  <= IGNORE;
                            end
                        end
                        default: ;
                    endcase
                end
                if (fall_evt) begin
                    case (state)
                        ADDR_ACK: begin
                            if (cnt == 4'd8) begin
                                sda_drive_low_o <= 1'b1;
                            end else if (cnt == 4'd9) begin
                                sda_drive_low_o <= 1'b0;
                                cnt             <= 4'd0;
                                state           <= rw ? RD_BYTE : WR_BYTE;
                            end
                        end
                        WR_ACK: begin
                            if (cnt == 4'd8) begin
                                sda_drive_low_o <= ack_wr;
                            end else if (cnt == 4'd9) begin
                                sda_drive_low_o <= 1'b0;
                                cnt             <= 4'd0;
                                state           <= WR_BYTE;
                            end
                        end
                        RD_BYTE: begin
                            if (cnt == 4'd8) begin
                                sda_drive_low_o <= 1'b0;
                                state           <= RD_ACK;
                            end else begin
                                sda_drive_low_o <= ~shreg[7];
                                shreg           <= {shreg[6:0], 1'b0};
                            end
                        end
                        RD_ACK: begin
                            if (cnt == 4'd9) begin
                                cnt   <= 4'd0;
                                state <= RD_BYTE;
                            end
                        end
                        default: ;
                    endcase
                end
                // MSB goes on the bus at the latch point; the rest shifts out.
                if (latch_pt) begin
                    if (tx_valid_i) begin
                        shreg           <= {tx_data_i[6:0], 1'b0};
                        sda_drive_low_o <= ~tx_data_i[7];
                    end else begin
`ifdef I2C_TARGET_CLK_STRETCH_EN
                        scl_drv         <= 1'b1;
                        stretch         <= 1'b1;
                        sda_drive_low_o <= 1'b0;
`else
                        shreg           <= 8'hFE;
                        sda_drive_low_o <= 1'b0;
                        underrun_o      <= 1'b1;
`endif
                    end
                end
`ifdef I2C_TARGET_CLK_STRETCH_EN
                if (stretch && tx_valid_i) begin
                    stretch         <= 1'b0;
                    shreg           <= {tx_data_i[6:0], 1'b0};
                    sda_drive_low_o <= ~tx_data_i[7];
                    rel_act         <= 1'b1;
                    rel_cnt         <= HW'(HOLD_CYCLES);
                end
                if (rel_act) begin
                    if (rel_cnt == '0) begin
                        rel_act <= 1'b0;
                        scl_drv <= 1'b0;
                    end else begin
                        rel_cnt <= rel_cnt - 1'b1;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: bus-level I2C master tasks with RX/TX scoreboards.
// Open-drain bus modelled as wired-AND of master and target pull-downs.
`timescale 1ns/1ps
module tb_i2c_target_responder;

    localparam int Q = 12;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       scl_m;
    logic       sda_m;
    logic       scl_i;
    logic       sda_i;
    logic       scl_drive_low_o;
    logic       sda_drive_low_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic       start_o;
    logic       stop_o;
    logic       nack_o;
    logic       underrun_o;
    logic       busy_o;

    int total = 0;
    int bad   = 0;
    int n_start = 0;
    int n_stop  = 0;
    int n_nack  = 0;
    int n_under = 0;
    int n_txr   = 0;
    int n_rxv   = 0;
    int n_sdal  = 0;
    int n_scll  = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] src_q[$];

    assign scl_i = scl_m & ~scl_drive_low_o;
    assign sda_i = sda_m & ~sda_drive_low_o;

    always #5 clk_i = ~clk_i;

    i2c_target_responder dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .scl_i           (scl_i),
        .sda_i           (sda_i),
        .scl_drive_low_o (scl_drive_low_o),
        .sda_drive_low_o (sda_drive_low_o),
        .rx_data_o       (rx_data_o),
        .rx_valid_o      (rx_valid_o),
        .rx_ready_i      (rx_ready_i),
        .tx_data_i       (tx_data_i),
        .tx_valid_i      (tx_valid_i),
        .tx_ready_o      (tx_ready_o),
        .start_o         (start_o),
        .stop_o          (stop_o),
        .nack_o          (nack_o),
        .underrun_o      (underrun_o),
        .busy_o          (busy_o)
    );

    // Pulse counters and the RX scoreboard, sampled on the falling clock edge.
    always @(negedge clk_i) begin
        if (start_o)         n_start++;
        if (stop_o)          n_stop++;
        if (nack_o)          n_nack++;
        if (underrun_o)      n_under++;
        if (sda_drive_low_o) n_sdal++;
        if (scl_drive_low_o) n_scll++;
        if (rx_valid_o) begin
            n_rxv++;
            total++;
            if (exp_rx.size() == 0) begin
                bad++;
                $display("FAIL rx_unexpected got=%h want=none", rx_data_o);
            end else begin
                logic [7:0] e;
                e = exp_rx.pop_front();
                if (rx_data_o !== e) begin
                    bad++;
                    $display("FAIL rx_data got=%h want=%h", rx_data_o, e);
                end
            end
        end
    end

    // TX source: presents the queue head, pops after a handshake edge.
    initial begin
        tx_valid_i = 1'b0;
        tx_data_i  = 8'h00;
        forever begin
            @(negedge clk_i);
            tx_valid_i = (src_q.size() != 0);
            if (src_q.size() != 0) tx_data_i = src_q[0];
            else                   tx_data_i = 8'h00;
            #1;
            if (tx_ready_o) begin
                n_txr++;
                @(posedge clk_i);
                #1;
                void'(src_q.pop_front());
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_scl_high();
        int k;
        k = 0;
        while (!scl_i && k < 4000) begin
            @(posedge clk_i);
            k++;
        end
        #1;
        total++;
        if (scl_i !== 1'b1) begin
            bad++;
            $display("FAIL scl_release got=%b want=1", scl_i);
        end
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        wait_clk(Q);
        sda_m = b;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_scl_high();
        wait_clk(Q);
        r = sda_i;
        wait_clk(Q);
        scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic acked);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
        bit_xfer(1'b1, r);
        acked = ~r;
    endtask

    task automatic read_byte(input logic nak, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        bit_xfer(nak, r);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(2 * Q);
        scl_m = 1'b0;
    endtask

    task automatic i2c_rstart();
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_scl_high();
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_scl_high();
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(2 * Q);
    endtask

    task automatic test_reset();
        logic [18:0] o;
        rst_n_i    = 1'b0;
        rx_ready_i = 1'b1;
        scl_m      = 1'b1;
        sda_m      = 1'b1;
        wait_clk(5);
        o = {scl_drive_low_o, sda_drive_low_o, rx_data_o, rx_valid_o,
             tx_ready_o, start_o, stop_o, nack_o, underrun_o, busy_o};
        total++;
        if (o !== 19'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", o);
        end
        rst_n_i = 1'b1;
        wait_clk(20);
        total++;
        if (busy_o !== 1'b0 || n_start != 0) begin
            bad++;
            $display("FAIL idle_after_reset got=busy%b/st%0d want=0/0",
                     busy_o, n_start);
        end
    endtask

    task automatic test_write();
        logic [7:0] wb[3];
        logic       a;
        int         acks, s0, p0, r0;
        wb   = '{8'h11, 8'h22, 8'h33};
        acks = 0;
        s0   = n_start;
        p0   = n_stop;
        r0   = n_rxv;
        i2c_start();
        total++;
        if (busy_o !== 1'b1) begin
            bad++;
            $display("FAIL busy_after_start got=%b want=1", busy_o);
        end
        write_byte(8'h44, a);
        if (a) acks++;
        for (int i = 0; i < 3; i++) begin
            exp_rx.push_back(wb[i]);
            write_byte(wb[i], a);
            if (a) acks++;
        end
        i2c_stop();
        total++;
        if (acks != 4) begin
            bad++;
            $display("FAIL write_acks got=%0d want=4", acks);
        end
        total++;
        if (n_rxv - r0 != 3 || exp_rx.size() != 0) begin
            bad++;
            $display("FAIL write_rx_count got=%0d want=3", n_rxv - r0);
        end
        total++;
        if (n_start - s0 != 1 || n_stop - p0 != 1) begin
            bad++;
            $display("FAIL write_start_stop got=%0d/%0d want=1/1",
                     n_start - s0, n_stop - p0);
        end
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL busy_after_stop got=%b want=0", busy_o);
        end
    endtask

    task automatic test_read();
        logic [7:0] exp_rd[$];
        logic [7:0] d;
        logic [7:0] e;
        logic       a;
        int         t0, k0;
        t0 = n_txr;
        k0 = n_nack;
        src_q.push_back(8'hA5);
        exp_rd.push_back(8'hA5);
        src_q.push_back(8'h5A);
        exp_rd.push_back(8'h5A);
        i2c_start();
        write_byte(8'h45, a);
        total++;
        if (a !== 1'b1) begin
            bad++;
            $display("FAIL read_addr_ack got=%b want=1", a);
        end
        read_byte(1'b0, d);
        e = exp_rd.pop_front();
        total++;
        if (d !== e) begin
            bad++;
            $display("FAIL read_byte0 got=%h want=%h", d, e);
        end
        read_byte(1'b1, d);
        e = exp_rd.pop_front();
        total++;
        if (d !== e) begin
            bad++;
            $display("FAIL read_byte1 got=%h want=%h", d, e);
        end
        i2c_stop();
        total++;
        if (n_txr - t0 != 2 || n_nack - k0 != 1) begin
            bad++;
            $display("FAIL read_pulses got=txr%0d/nack%0d want=2/1",
                     n_txr - t0, n_nack - k0);
        end
    endtask

    task automatic test_ignore();
        logic a;
        int   acks, l0, r0;
        acks = 0;
        l0   = n_sdal;
        r0   = n_rxv;
        i2c_start();
        write_byte(8'h46, a);
        if (a) acks++;
        write_byte(8'h12, a);
        if (a) acks++;
        write_byte(8'h34, a);
        if (a) acks++;
        total++;
        if (busy_o !== 1'b1) begin
            bad++;
            $display("FAIL ignore_busy got=%b want=1", busy_o);
        end
        i2c_stop();
        total++;
        if (acks != 0 || n_sdal != l0) begin
            bad++;
            $display("FAIL ignore_drive got=acks%0d/low%0d want=0/0",
                     acks, n_sdal - l0);
        end
        total++;
        if (n_rxv != r0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL ignore_rx_busy got=%0d/%b want=0/0",
                     n_rxv - r0, busy_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic       a1, a2, a3;
        int         s0, p0, t0, r0;
        s0 = n_start;
        p0 = n_stop;
        t0 = n_txr;
        r0 = n_rxv;
        src_q.push_back(8'hC3);
        i2c_start();
        write_byte(8'h44, a1);
        exp_rx.push_back(8'h7E);
        write_byte(8'h7E, a2);
        i2c_rstart();
        write_byte(8'h45, a3);
        read_byte(1'b1, d);
        i2c_stop();
        total++;
        if ({a1, a2, a3} !== 3'b111) begin
            bad++;
            $display("FAIL b2b_acks got=%b want=111", {a1, a2, a3});
        end
        total++;
        if (d !== 8'hC3) begin
            bad++;
            $display("FAIL b2b_read got=%h want=c3", d);
        end
        total++;
        if (n_start - s0 != 2 || n_stop - p0 != 1 ||
            n_txr - t0 != 1 || n_rxv - r0 != 1) begin
            bad++;
            $display("FAIL b2b_pulses got=%0d/%0d/%0d/%0d want=2/1/1/1",
                     n_start - s0, n_stop - p0, n_txr - t0, n_rxv - r0);
        end
    endtask

    task automatic test_nack_underrun();
        logic [7:0] d;
        logic       a;
        int         r0, u0, t0, c0;
        r0 = n_rxv;
        rx_ready_i = 1'b0;
        i2c_start();
        write_byte(8'h44, a);
        total++;
        if (a !== 1'b1) begin
            bad++;
            $display("FAIL nrdy_addr_ack got=%b want=1", a);
        end
        write_byte(8'h99, a);
        total++;
        if (a !== 1'b0) begin
            bad++;
            $display("FAIL nrdy_data_nack got=%b want=0", a);
        end
        i2c_stop();
        rx_ready_i = 1'b1;
        total++;
        if (n_rxv != r0) begin
            bad++;
            $display("FAIL nrdy_rx_valid got=%0d want=0", n_rxv - r0);
        end
        u0 = n_under;
        t0 = n_txr;
        c0 = n_scll;
        i2c_start();
        write_byte(8'h45, a);
`ifdef I2C_TARGET_CLK_STRETCH_EN
        fork
            begin
                wait_clk(300);
                src_q.push_back(8'h3C);
            end
        join_none
        read_byte(1'b1, d);
        i2c_stop();
        total++;
        if (d !== 8'h3C) begin
            bad++;
            $display("FAIL stretch_data got=%h want=3c", d);
        end
        total++;
        if (n_under != u0 || n_txr - t0 != 1 || n_scll == c0) begin
            bad++;
            $display("FAIL stretch_pulses got=u%0d/t%0d/s%0d want=0/1/>0",
                     n_under - u0, n_txr - t0, n_scll - c0);
        end
`else
        read_byte(1'b1, d);
        i2c_stop();
        total++;
        if (d !== 8'hFF) begin
            bad++;
            $display("FAIL underrun_data got=%h want=ff", d);
        end
        total++;
        if (n_under - u0 != 1 || n_txr != t0 || n_scll != c0) begin
            bad++;
            $display("FAIL underrun_pulses got=u%0d/t%0d/s%0d want=1/0/0",
                     n_under - u0, n_txr - t0, n_scll - c0);
        end
`endif
    endtask

    task automatic test_reset_midread();
        logic a;
        logic r;
        src_q.push_back(8'h00);
        i2c_start();
        write_byte(8'h45, a);
        bit_xfer(1'b1, r);
        bit_xfer(1'b1, r);
        wait_clk(Q);
        total++;
        if (sda_drive_low_o !== 1'b1) begin
            bad++;
            $display("FAIL midread_driving got=%b want=1", sda_drive_low_o);
        end
        #3;
        rst_n_i = 1'b0;
        #1;
        total++;
        if (sda_drive_low_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got=%b/%b want=0/0",
                     sda_drive_low_o, busy_o);
        end
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_clk(10);
        rst_n_i = 1'b1;
        wait_clk(20);
        i2c_start();
        write_byte(8'h44, a);
        i2c_stop();
        total++;
        if (a !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_ack got=%b want=1", a);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_ignore();
        test_back_to_back();
        test_nack_underrun();
        test_reset_midread();
        wait_clk(20);
        total++;
        if (exp_rx.size() != 0 || src_q.size() != 0) begin
            bad++;
            $display("FAIL queues_drained got=%0d/%0d want=0/0",
                     exp_rx.size(), src_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
